// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, default widths and result sentinel for the LSU dispatcher
package lsu_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    localparam int DEF_NUM_LSU          = 4;
    localparam int DEF_MACHINE_COUNT    = 10;
    localparam int DEF_MAX_BUTTON_COUNT = 13;
    localparam int DEF_BITS_PER_JOLTAGE = 9;
    localparam int DEF_ANSWER_BIT_WIDTH = 16;
    localparam int DEF_TOTAL_BIT_WIDTH  = 32;
    localparam logic [DEF_ANSWER_BIT_WIDTH-1:0] ANSWER_ALL_ONES = '1;
endpackage

// File: rtl/lsu_dispatcher_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starts one past the previous grant
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;
    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % N);
    endfunction
    // Walk downward so the request closest to the pointer is the last one written.
    always_comb begin
        o_grant = '0;
        w_next = r_ptr;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[wrap(int'(r_ptr) + i)]) begin
                o_grant = '0;
                o_grant[wrap(int'(r_ptr) + i)] = 1'b1;
                w_next = wrap(int'(r_ptr) + i + 1);
            end
        end
    end
    always_ff @(posedge clk)
        r_ptr <= !reset ? '0 : (i_advance && |i_req) ? w_next : r_ptr;
endmodule

// File: rtl/lsu_dispatcher.sv
// lsu_dispatcher: issues parsed lines to free LSUs round-robin and accumulates their results
module lsu_dispatcher
    import lsu_pkg::*;
#(
    parameter int NUM_LSU          = DEF_NUM_LSU,
    parameter int MACHINE_COUNT    = DEF_MACHINE_COUNT,
    parameter int MAX_BUTTON_COUNT = DEF_MAX_BUTTON_COUNT,
    parameter int BITS_PER_JOLTAGE = DEF_BITS_PER_JOLTAGE,
    parameter int ANSWER_BIT_WIDTH = DEF_ANSWER_BIT_WIDTH,
    parameter int TOTAL_BIT_WIDTH  = DEF_TOTAL_BIT_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic                                       in_last,
    input  logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]      in_button_count,
    input  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0]  in_flattened_buttons,
    input  logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0]  in_flattened_machines,
    output logic [NUM_LSU-1:0]                         lsu_start,
    output logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]      lsu_button_count,
    output logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0]  lsu_flattened_buttons,
    output logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0]  lsu_flattened_machines,
    input  logic [NUM_LSU-1:0]                         lsu_available,
    input  logic [NUM_LSU-1:0]                         lsu_result_ready,
    input  logic [NUM_LSU*ANSWER_BIT_WIDTH-1:0]        lsu_result,
    output logic [TOTAL_BIT_WIDTH-1:0]                 total,
    output logic [15:0]                                lines_issued,
    output logic [15:0]                                lines_done,
    output logic [NUM_LSU-1:0]                         busy_mask,
    output logic                                       unsolved,
    output logic                                       done
);
    state_t                     r_state;
    logic [NUM_LSU-1:0]         w_free;
    logic [NUM_LSU-1:0]         w_grant;
    logic [NUM_LSU-1:0]         w_hit;
    logic                       w_accept;
    logic                       w_unsolved;
    logic [TOTAL_BIT_WIDTH-1:0] w_sum;
    logic [15:0]                w_cnt;
    assign w_free   = lsu_available & ~busy_mask;
    assign in_ready = r_state == S_RUN && |w_free;
    assign w_accept = in_valid && in_ready;
    assign w_hit    = (r_state == S_RUN || r_state == S_DRAIN) ? lsu_result_ready & busy_mask : '0;
    rr_arbiter #(.N(NUM_LSU)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_free),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );
    // All-ones marks an unsolvable line: flagged, never summed.
    always_comb begin
        w_sum = '0;
        w_cnt = '0;
        w_unsolved = 1'b0;
        for (int k = 0; k < NUM_LSU; k++) begin
            if (w_hit[k]) begin
                w_cnt = w_cnt + 16'd1;
                w_unsolved = w_unsolved | &lsu_result[k*ANSWER_BIT_WIDTH +: ANSWER_BIT_WIDTH];
                w_sum = w_sum + (&lsu_result[k*ANSWER_BIT_WIDTH +: ANSWER_BIT_WIDTH] ? '0 :
                        TOTAL_BIT_WIDTH'(lsu_result[k*ANSWER_BIT_WIDTH +: ANSWER_BIT_WIDTH]));
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state                <= S_IDLE;
            lsu_start              <= '0;
            lsu_button_count       <= '0;
            lsu_flattened_buttons  <= '0;
            lsu_flattened_machines <= '0;
            total                  <= '0;
            lines_issued           <= '0;
            lines_done             <= '0;
            busy_mask              <= '0;
            unsolved               <= 1'b0;
            done                   <= 1'b0;
        end else if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
            r_state      <= S_RUN;
            lsu_start    <= '0;
            total        <= '0;
            lines_issued <= '0;
            lines_done   <= '0;
            busy_mask    <= '0;
            unsolved     <= 1'b0;
            done         <= 1'b0;
        end else begin
            lsu_start <= w_accept ? w_grant : '0;
            if (w_accept) begin
                lsu_button_count       <= in_button_count;
                lsu_flattened_buttons  <= in_flattened_buttons;
                lsu_flattened_machines <= in_flattened_machines;
                lines_issued           <= lines_issued + 16'd1;
            end
            busy_mask  <= (busy_mask & ~w_hit) | (w_accept ? w_grant : '0);
            total      <= total + w_sum;
            lines_done <= lines_done + w_cnt;
            unsolved   <= unsolved | w_unsolved;
            r_state    <= (r_state == S_RUN && w_accept && in_last) ? S_DRAIN :
                          (r_state == S_DRAIN && busy_mask == '0) ? S_DONE : r_state;
            done       <= done | (r_state == S_DRAIN && busy_mask == '0);
        end
    end
endmodule

// File: tb/tb_lsu_dispatcher.sv
// tb_lsu_dispatcher: directed jobs against behavioural LSUs, grant/payload scoreboard and totals
module tb_lsu_dispatcher;
    import lsu_pkg::*;
    typedef struct {
        int           unit;
        logic [3:0]   bc;
        logic [129:0] btn;
        logic [89:0]  mach;
    } exp_t;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [3:0]   in_button_count = '0;
    logic [129:0] in_flattened_buttons = '0;
    logic [89:0]  in_flattened_machines = '0;
    logic         in_ready;
    logic [3:0]   lsu_start;
    logic [3:0]   lsu_button_count;
    logic [129:0] lsu_flattened_buttons;
    logic [89:0]  lsu_flattened_machines;
    logic [3:0]   lsu_available;
    logic [3:0]   lsu_result_ready;
    logic [63:0]  lsu_result;
    logic [31:0]  total;
    logic [15:0]  lines_issued, lines_done;
    logic [3:0]   busy_mask;
    logic         unsolved, done;
    logic         start2 = 1'b0;
    logic [3:0]   rdy2 = '0;
    logic [63:0]  res2 = '0;
    logic         in_ready2;
    logic [3:0]   lsu_start2;
    logic [3:0]   lbc2;
    logic [129:0] lfb2;
    logic [89:0]  lfm2;
    logic [15:0]  total2;
    logic [15:0]  li2, ld2;
    logic [3:0]   busy2;
    logic         uns2, done2;
    logic [3:0]   m_busy, m_rdy;
    logic [3:0]   spur = '0;
    int           m_cnt [4];
    logic [15:0]  m_res [4];
    exp_t         sb [$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [31:0]  t0;
    logic [15:0]  d0;

    always #5 clk = ~clk;

    lsu_dispatcher dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_button_count(in_button_count),
        .in_flattened_buttons(in_flattened_buttons), .in_flattened_machines(in_flattened_machines),
        .lsu_start(lsu_start), .lsu_button_count(lsu_button_count),
        .lsu_flattened_buttons(lsu_flattened_buttons), .lsu_flattened_machines(lsu_flattened_machines),
        .lsu_available(lsu_available), .lsu_result_ready(lsu_result_ready), .lsu_result(lsu_result),
        .total(total), .lines_issued(lines_issued), .lines_done(lines_done),
        .busy_mask(busy_mask), .unsolved(unsolved), .done(done)
    );

    lsu_dispatcher #(.TOTAL_BIT_WIDTH(16)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_last(in_last), .in_button_count(in_button_count),
        .in_flattened_buttons(in_flattened_buttons), .in_flattened_machines(in_flattened_machines),
        .lsu_start(lsu_start2), .lsu_button_count(lbc2),
        .lsu_flattened_buttons(lfb2), .lsu_flattened_machines(lfm2),
        .lsu_available(4'b1111), .lsu_result_ready(rdy2), .lsu_result(res2),
        .total(total2), .lines_issued(li2), .lines_done(ld2),
        .busy_mask(busy2), .unsolved(uns2), .done(done2)
    );

    // Behavioural LSU: answer is the low 16 payload bits, latency 2*button_count cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!reset) begin
                m_busy[k] <= 1'b0;
                m_rdy[k]  <= 1'b0;
                m_cnt[k]  <= 0;
                m_res[k]  <= '0;
            end else begin
                m_rdy[k] <= 1'b0;
                if (lsu_start[k]) begin
                    m_busy[k] <= 1'b1;
                    m_cnt[k]  <= 2 * int'(lsu_button_count);
                    m_res[k]  <= lsu_flattened_machines[15:0];
                end else if (m_busy[k]) begin
                    if (m_cnt[k] > 1) m_cnt[k] <= m_cnt[k] - 1;
                    else begin
                        m_rdy[k]  <= 1'b1;
                        m_busy[k] <= 1'b0;
                    end
                end
            end
        end
    end
    assign lsu_available    = ~m_busy;
    assign lsu_result_ready = m_rdy | spur;
    always_comb begin
        lsu_result = '0;
        for (int k = 0; k < 4; k++) lsu_result[k*16 +: 16] = spur[k] ? 16'd100 : m_res[k];
    end

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every cycle advance also checks any start pulse against the next expected grant.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (lsu_start !== 4'b0000) begin
            if (sb.size() == 0) chk("unexpected_start", {126'd0, lsu_start}, 130'd0);
            else begin
                e = sb.pop_front();
                chk("grant", {126'd0, lsu_start}, 130'(4'b0001 << e.unit));
                chk("pl_count", {126'd0, lsu_button_count}, {126'd0, e.bc});
                chk("pl_buttons", lsu_flattened_buttons, e.btn);
                chk("pl_machines", {40'd0, lsu_flattened_machines}, {40'd0, e.mach});
            end
        end
    endtask

    task automatic send(input int unit, input logic [15:0] val, input logic [3:0] bc, input logic last);
        exp_t         e;
        logic [159:0] rb;
        logic [95:0]  rm;
        int           n;
        n  = 0;
        rb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        rm = {$urandom(), $urandom(), $urandom()};
        in_valid = 1'b1;
        in_last = last;
        in_button_count = bc;
        in_flattened_buttons = rb[129:0];
        in_flattened_machines = {rm[89:16], val};
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("ready_wait", {129'd0, in_ready}, 130'd1);
        e.unit = unit;
        e.bc   = bc;
        e.btn  = rb[129:0];
        e.mach = {rm[89:16], val};
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        chk("done_wait", {129'd0, done}, 130'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        do_reset();
        chk("rst_total", {98'd0, total}, 130'd0);
        chk("rst_issued", {114'd0, lines_issued}, 130'd0);
        chk("rst_done_cnt", {114'd0, lines_done}, 130'd0);
        chk("rst_busy", {126'd0, busy_mask}, 130'd0);
        chk("rst_flags", {127'd0, unsolved, done, lsu_start != 4'b0000}, 130'd0);
        chk("rst_ready", {129'd0, in_ready}, 130'd0);

        // single line, 20-cycle LSU, result 7
        pulse_start();
        send(0, 16'd7, 4'd10, 1'b1);
        n = 0;
        while (!lsu_result_ready[0] && n < 100) begin
            tick();
            n++;
        end
        chk("t1_result_seen", {129'd0, lsu_result_ready[0]}, 130'd1);
        tick();
        chk("t1_total", {98'd0, total}, 130'd7);
        chk("t1_busy", {126'd0, busy_mask}, 130'd0);
        chk("t1_done_early", {129'd0, done}, 130'd0);
        tick();
        chk("t1_done", {129'd0, done}, 130'd1);
        chk("t1_lines_done", {114'd0, lines_done}, 130'd1);
        chk("t1_lines_issued", {114'd0, lines_issued}, 130'd1);

        // six lines over four units
        do_reset();
        pulse_start();
        send(0, 16'd1, 4'd3, 1'b0);
        send(1, 16'd2, 4'd12, 1'b0);
        send(2, 16'd3, 4'd12, 1'b0);
        send(3, 16'd4, 4'd12, 1'b0);
        chk("t2_full_ready", {129'd0, in_ready}, 130'd0);
        chk("t2_full_busy", {126'd0, busy_mask}, 130'hF);
        send(0, 16'd5, 4'd13, 1'b0);
        send(1, 16'd6, 4'd1, 1'b1);
        wait_done();
        chk("t2_total", {98'd0, total}, 130'd21);
        chk("t2_lines_done", {114'd0, lines_done}, 130'd6);
        chk("t2_lines_issued", {114'd0, lines_issued}, 130'd6);

        // units 1 and 3 report in the same cycle
        do_reset();
        pulse_start();
        send(0, 16'd2, 4'd2, 1'b0);
        send(1, 16'd5, 4'd6, 1'b0);
        send(2, 16'd4, 4'd12, 1'b0);
        send(3, 16'd9, 4'd5, 1'b1);
        n = 0;
        while (!(lsu_result_ready[1] && lsu_result_ready[3]) && n < 100) begin
            tick();
            n++;
        end
        chk("t3_pair_seen", {128'd0, lsu_result_ready[3], lsu_result_ready[1]}, 130'd3);
        t0 = total;
        d0 = lines_done;
        tick();
        chk("t3_total_step", {98'd0, total}, {98'd0, t0 + 32'd14});
        chk("t3_lines_step", {114'd0, lines_done}, {114'd0, d0 + 16'd2});
        chk("t3_busy", {126'd0, busy_mask}, 130'h4);
        wait_done();
        chk("t3_total", {98'd0, total}, 130'd20);
        chk("t3_lines_done", {114'd0, lines_done}, 130'd4);

        // all-ones result is flagged, not summed
        do_reset();
        pulse_start();
        send(0, ANSWER_ALL_ONES, 4'd2, 1'b0);
        send(1, 16'd3, 4'd3, 1'b1);
        wait_done();
        chk("t4_unsolved", {129'd0, unsolved}, 130'd1);
        chk("t4_total", {98'd0, total}, 130'd3);
        chk("t4_lines_done", {114'd0, lines_done}, 130'd2);
        pulse_start();
        chk("t4_restart_clear", {98'd0, total}, 130'd0);
        chk("t4_restart_flags", {128'd0, unsolved, done}, 130'd0);
        chk("t4_restart_cnt", {114'd0, lines_done}, 130'd0);

        // reset while draining with two units busy
        send(2, 16'd1, 4'd10, 1'b0);
        send(3, 16'd2, 4'd10, 1'b1);
        chk("t6_busy_pre", {126'd0, busy_mask}, 130'hC);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_total", {98'd0, total}, 130'd0);
        chk("t6_counts", {98'd0, lines_issued, lines_done}, 130'd0);
        chk("t6_busy", {126'd0, busy_mask}, 130'd0);
        chk("t6_flags", {125'd0, unsolved, done, in_ready, lsu_start != 4'b0000, lsu_button_count != 4'd0}, 130'd0);
        chk("t6_payload", lsu_flattened_buttons, 130'd0);
        reset = 1'b1;
        tick();
        chk("t6_idle", {129'd0, in_ready}, 130'd0);

        // clean job with a spurious pulse from an idle unit
        pulse_start();
        send(0, 16'd11, 4'd3, 1'b0);
        spur = 4'b0100;
        tick();
        spur = 4'b0000;
        chk("t7_spur_total", {98'd0, total}, 130'd0);
        chk("t7_spur_lines", {114'd0, lines_done}, 130'd0);
        chk("t7_spur_busy", {126'd0, busy_mask}, 130'h1);
        send(1, 16'd1, 4'd1, 1'b1);
        wait_done();
        chk("t7_total", {98'd0, total}, 130'd12);
        chk("t7_lines_done", {114'd0, lines_done}, 130'd2);
        chk("t7_unsolved", {129'd0, unsolved}, 130'd0);

        // narrow accumulator wraps
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        in_valid = 1'b1;
        in_button_count = 4'd1;
        chk("t5_ready", {129'd0, in_ready2}, 130'd1);
        tick();
        chk("t5_grant0", {126'd0, lsu_start2}, 130'h1);
        in_last = 1'b1;
        tick();
        chk("t5_grant1", {126'd0, lsu_start2}, 130'h2);
        in_valid = 1'b0;
        in_last = 1'b0;
        res2 = {32'd0, 16'd30000, 16'd40000};
        rdy2 = 4'b0011;
        tick();
        rdy2 = 4'b0000;
        chk("t5_wrap_total", {114'd0, total2}, 130'd4464);
        chk("t5_lines", {114'd0, ld2}, 130'd2);
        tick();
        chk("t5_done", {129'd0, done2}, 130'd1);

        chk("sb_empty", 130'(sb.size()), 130'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
